// File: rtl/peripheral_interrupt_gateway.sv
// Peripheral interrupt gateway: per-line edge/level capture, pending latch,
// overrun flagging and backpressured delivery. Define PIRQ_SYNC_EN for 2-flop input sync.
module peripheral_interrupt_gateway #(
    parameter int NUM_INTER = 54
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_INTER-1:0] irq_in,
    input  logic [NUM_INTER-1:0] edge_mode,
    input  logic [NUM_INTER-1:0] i_enable,
    input  logic [NUM_INTER-1:0] rearm,
    input  logic                 q_ready,
    input  logic [NUM_INTER-1:0] overrun_clr,
    output logic [NUM_INTER-1:0] interrupts,
    output logic [NUM_INTER-1:0] pending,
    output logic [NUM_INTER-1:0] overrun
);

    logic [NUM_INTER-1:0] s;
    logic [NUM_INTER-1:0] prev;
    logic [NUM_INTER-1:0] armed;
    logic [NUM_INTER-1:0] evt;
    logic [NUM_INTER-1:0] evt_en;
    logic [NUM_INTER-1:0] deliver;
    logic [NUM_INTER-1:0] arm_clr;
    logic [1:0]           warm;
    logic                 hist_ok;

`ifdef PIRQ_SYNC_EN
    localparam logic [1:0] WARM_DONE = 2'd3;
    logic [NUM_INTER-1:0] sync1;
    logic [NUM_INTER-1:0] sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    localparam logic [1:0] WARM_DONE = 2'd1;
    assign s = irq_in;
`endif

    // Edge detection stays off until prev holds a real post-reset sample, so a
    // line held high across reset release is not mistaken for a rising edge.
    assign hist_ok = (warm == WARM_DONE);

    always_comb begin
        evt     = (edge_mode & s & ~prev & {NUM_INTER{hist_ok}})
                | (~edge_mode & s & armed);
        evt_en  = evt & i_enable;
        deliver = q_ready ? (pending & i_enable) : '0;
        // Edge-mode lines disarm while high so a switch to level mode cannot fire spuriously.
        arm_clr = (edge_mode & s) | (~edge_mode & evt_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm       <= '0;
            prev       <= '0;
            armed      <= '1;
            pending    <= '0;
            overrun    <= '0;
            interrupts <= '0;
        end else begin
            if (!hist_ok) warm <= warm + 2'd1;
            prev       <= s;
            armed      <= (armed & ~arm_clr) | ~s | rearm;
            pending    <= ((pending & ~deliver) | evt_en) & i_enable;
            overrun    <= (evt_en & pending & ~deliver) | (overrun & ~overrun_clr);
            interrupts <= deliver;
        end
    end

endmodule

// File: tb/tb_peripheral_interrupt_gateway.sv
// Self-checking bench for peripheral_interrupt_gateway; latency follows PIRQ_SYNC_EN.
module tb_peripheral_interrupt_gateway;

    localparam int N = 54;
`ifdef PIRQ_SYNC_EN
    localparam int L = 4;
`else
    localparam int L = 2;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] irq_in, edge_mode, i_enable, rearm, overrun_clr;
    logic         q_ready;
    logic [N-1:0] interrupts, pending, overrun;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_v;
    int           n_checks = 0;
    int           n_fail = 0;

    peripheral_interrupt_gateway #(.NUM_INTER(N)) dut (
        .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .edge_mode(edge_mode),
        .i_enable(i_enable), .rearm(rearm), .q_ready(q_ready),
        .overrun_clr(overrun_clr), .interrupts(interrupts), .pending(pending),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; irq_in = '0; edge_mode = '1; i_enable = '1;
        rearm = '0; overrun_clr = '0; q_ready = 1'b1;
        irq_in[1] = 1'b1; irq_in[2] = 1'b1; edge_mode[2] = 1'b0;
        #2;
        n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_checks++; if (overrun !== '0) begin n_fail++; $display("FAIL reset_overrun: got %h want 0", overrun); end
        n_checks++; if (interrupts !== '0) begin n_fail++; $display("FAIL reset_interrupts: got %h want 0", interrupts); end
        step(); step();
        reset_n = 1'b1;
        // Edge line 1 held high across release stays silent; level line 2 fires once.
        for (int k = 1; k <= L + 4; k++) begin
            exp_v = '0; if (k == L) exp_v[2] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= L + 4; k++) begin
            step(); exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL release_held k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        irq_in = '0;
        repeat (L + 2) step();
        irq_in[1] = 1'b1;
        for (int k = 1; k <= L + 2; k++) begin
            exp_v = '0; if (k == L) exp_v[1] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= L + 2; k++) begin
            step(); exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL fresh_edge k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        irq_in[1] = 1'b0;
        repeat (L + 1) step();
    endtask

    task automatic test_edge_latency();
        irq_in[3] = 1'b1;
        for (int k = 1; k <= L + 6; k++) begin
            exp_v = '0; if (k == L) exp_v[3] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= L + 6; k++) begin
            step(); exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL edge_latency k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        irq_in[3] = 1'b0;
        repeat (L + 1) step();
    endtask

    task automatic test_backpressure();
        q_ready = 1'b0;
        irq_in[0] = 1'b1; irq_in[7] = 1'b1;
        step();
        irq_in[0] = 1'b0; irq_in[7] = 1'b0;
        repeat (L) begin
            step();
            n_checks++; if (interrupts !== '0) begin n_fail++; $display("FAIL bp_hold_int: got %h want 0", interrupts); end
        end
        n_checks++; if (pending !== 54'h81) begin n_fail++; $display("FAIL bp_pending: got %h want 81", pending); end
        q_ready = 1'b1;
        exp_q.push_back(54'h81);
        exp_q.push_back(54'h0);
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL bp_release: got %h want %h", interrupts, exp_v); end
        n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL bp_pending_clr: got %h want 0", pending); end
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL bp_one_cycle: got %h want %h", interrupts, exp_v); end
    endtask

    task automatic test_overrun();
        q_ready = 1'b0;
        irq_in[5] = 1'b1; step();
        irq_in[5] = 1'b0; step(); step();
        irq_in[5] = 1'b1; step();
        irq_in[5] = 1'b0;
        repeat (L) step();
        n_checks++; if (pending[5] !== 1'b1) begin n_fail++; $display("FAIL ovr_pending: got %b want 1", pending[5]); end
        n_checks++; if (overrun[5] !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun[5]); end
        overrun_clr[5] = 1'b1; step();
        overrun_clr[5] = 1'b0;
        n_checks++; if (overrun[5] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun[5]); end
        n_checks++; if (pending[5] !== 1'b1) begin n_fail++; $display("FAIL ovr_pending_kept: got %b want 1", pending[5]); end
        q_ready = 1'b1;
        exp_v = '0; exp_v[5] = 1'b1; exp_q.push_back(exp_v);
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL ovr_deliver: got %h want %h", interrupts, exp_v); end
        step();
    endtask

    task automatic test_back_to_back();
        // A new edge landing on the delivery edge is kept as a fresh pending event.
        q_ready = 1'b0;
        irq_in[6] = 1'b1; step();
        irq_in[6] = 1'b0;
        repeat (L) step();
        irq_in[6] = 1'b1;
        repeat (L - 2) step();
        q_ready = 1'b1;
        exp_v = '0; exp_v[6] = 1'b1;
        exp_q.push_back(exp_v); exp_q.push_back(exp_v); exp_q.push_back('0);
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h want %h", interrupts, exp_v); end
        n_checks++; if (pending[6] !== 1'b1) begin n_fail++; $display("FAIL b2b_pending: got %b want 1", pending[6]); end
        n_checks++; if (overrun[6] !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", overrun[6]); end
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL b2b_second: got %h want %h", interrupts, exp_v); end
        step(); exp_v = exp_q.pop_front();
        n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL b2b_idle: got %h want %h", interrupts, exp_v); end
        irq_in[6] = 1'b0;
        repeat (L + 1) step();
    endtask

    task automatic test_level_rearm();
        edge_mode[2] = 1'b0;
        irq_in[2] = 1'b1;
        for (int k = 1; k <= L + 5; k++) begin
            exp_v = '0; if (k == L) exp_v[2] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= L + 5; k++) begin
            step(); exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL level_first k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        rearm[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp_v = '0; if (k == 3) exp_v[2] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= 6; k++) begin
            step(); rearm[2] = 1'b0; exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL level_rearm k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        irq_in[2] = 1'b0;
        repeat (L + 1) step();
        irq_in[2] = 1'b1;
        for (int k = 1; k <= L + 4; k++) begin
            exp_v = '0; if (k == L) exp_v[2] = 1'b1;
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= L + 4; k++) begin
            step(); exp_v = exp_q.pop_front();
            n_checks++; if (interrupts !== exp_v) begin n_fail++; $display("FAIL level_relevel k=%0d: got %h want %h", k, interrupts, exp_v); end
        end
        irq_in[2] = 1'b0;
        repeat (L + 1) step();
    endtask

    task automatic test_disable_reset();
        q_ready = 1'b0;
        irq_in[9] = 1'b1; step();
        irq_in[9] = 1'b0;
        repeat (L) step();
        n_checks++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL dis_pending_set: got %b want 1", pending[9]); end
        i_enable[9] = 1'b0; step();
        n_checks++; if (pending[9] !== 1'b0) begin n_fail++; $display("FAIL dis_pending_clr: got %b want 0", pending[9]); end
        i_enable[9] = 1'b1; q_ready = 1'b1;
        repeat (3) begin
            step();
            n_checks++; if (interrupts !== '0) begin n_fail++; $display("FAIL dis_no_delivery: got %h want 0", interrupts); end
        end
        q_ready = 1'b0;
        irq_in[4] = 1'b1; step(); irq_in[4] = 1'b0; step(); step();
        irq_in[4] = 1'b1; step(); irq_in[4] = 1'b0;
        repeat (L) step();
        n_checks++; if (overrun[4] !== 1'b1 || pending[4] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: got p=%b o=%b want 1 1", pending[4], overrun[4]); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL async_pending: got %h want 0", pending); end
        n_checks++; if (overrun !== '0) begin n_fail++; $display("FAIL async_overrun: got %h want 0", overrun); end
        n_checks++; if (interrupts !== '0) begin n_fail++; $display("FAIL async_interrupts: got %h want 0", interrupts); end
        step();
        reset_n = 1'b1; q_ready = 1'b1;
        repeat (L + 2) begin
            step();
            n_checks++; if (interrupts !== '0) begin n_fail++; $display("FAIL post_reset_quiet: got %h want 0", interrupts); end
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_level_rearm();
        test_disable_reset();
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_interrupt_gateway.md
PERIPHERAL_INTERRUPT_GATEWAY -- requirements
Module: peripheral_interrupt_gateway

Interface
REQ-001 SHALL have parameter NUM_INTER, default 54, number of peripheral interrupt lines.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port irq_in  input  NUM_INTER  raw peripheral interrupt lines, asynchronous to clk.
REQ-005 SHALL have port edge_mode  input  NUM_INTER  per line: 1 = rising-edge sensitive, 0 = level sensitive.
REQ-006 SHALL have port i_enable  input  NUM_INTER  per-line enable from CSR.
REQ-007 SHALL have port rearm  input  NUM_INTER  one-cycle software re-arm pulse per line (level mode only).
REQ-008 SHALL have port q_ready  input  1  downstream queue can accept events (tied to queue-not-full).
REQ-009 SHALL have port overrun_clr  input  NUM_INTER  one-cycle clear pulses for overrun flags.
REQ-010 SHALL have port interrupts  output  NUM_INTER  registered one-cycle event pulses to the interrupt queue.
REQ-011 SHALL have port pending  output  NUM_INTER  latched, not-yet-delivered events.
REQ-012 SHALL have port overrun  output  NUM_INTER  sticky flag: event lost because line already pending.

Function
REQ-013 SHALL form per-line sampled value s[i] from irq_in (see Configuration) and keep prev[i] = s[i] delayed one cycle.
REQ-014 SHALL raise event[i] = s[i] & ~prev[i] when edge_mode[i]=1, and event[i] = s[i] & armed[i] when edge_mode[i]=0.
REQ-015 SHALL clear armed[i] when line i is delivered in level mode; SHALL set armed[i] when s[i]=0 or rearm[i]=1; rearm and delivery in same cycle -> armed stays set.
REQ-016 SHALL set pending[i] at the clock edge after event[i] & i_enable[i]; events on disabled lines are discarded.
REQ-017 SHALL, each cycle q_ready=1, register interrupts <= pending & i_enable and clear those pending bits at the same edge; all lines pending are delivered together.
REQ-018 SHALL drive interrupts to all zeros in any cycle following q_ready=0; pending bits are held, not lost.
REQ-019 SHALL assert each interrupts bit for exactly one cycle per delivery.
REQ-020 SHALL, when i_enable[i] is low, clear pending[i] at the next edge.
REQ-021 SHALL, on a new event on line i while pending[i]=1 and not being delivered that edge, keep pending[i]=1 and set overrun[i].
REQ-022 SHALL, on a new event on line i at the same edge pending[i] is delivered, deliver the old event and leave pending[i]=1 (new event kept, no overrun).
REQ-023 SHALL clear overrun[i] on overrun_clr[i]; a simultaneous set wins over clear.
REQ-024 SHALL treat an edge_mode change as taking effect the next cycle with no spurious event.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously clear synchronizer flops, prev, pending, overrun, interrupts to 0 and set armed to all ones.
REQ-026 SHALL, on reset release with a line held high in edge mode, produce no event until a fresh low-to-high transition; level mode lines fire once.
REQ-027 SHALL discard any in-flight pending events when reset asserts mid-operation.

Configuration
REQ-028 SHALL, when macro PIRQ_SYNC_EN is defined, form s[i] through a two-flop synchronizer on irq_in[i]: irq_in high before edge 1 -> interrupts high after edge 4 (q_ready=1).
REQ-029 SHALL, when PIRQ_SYNC_EN is undefined, use s[i] = irq_in[i] directly: irq_in high before edge 1 -> interrupts high after edge 2; irq_in then required synchronous to clk.

Verification
REQ-030 SHALL verify edge latency: PIRQ_SYNC_EN defined, edge_mode[3]=1, i_enable[3]=1, q_ready=1, irq_in[3] 0->1 held -> interrupts[3] high exactly one cycle, 4 edges later, never again while held.
REQ-031 SHALL verify backpressure: q_ready=0, pulse lines 0 and 7 -> pending=0x81 held, interrupts=0; raise q_ready -> interrupts=0x81 one cycle, pending=0.
REQ-032 SHALL verify overrun: q_ready=0, two separate rising edges on line 5 -> pending[5]=1, overrun[5]=1; overrun_clr[5] pulse -> overrun[5]=0, pending[5] still 1.
REQ-033 SHALL verify level re-arm: edge_mode[2]=0, irq_in[2] held high -> one delivery; rearm[2] pulse -> second delivery; irq_in[2] low then high -> third delivery.
REQ-034 SHALL verify disable and reset: pending[9]=1 then i_enable[9]=0 -> pending[9]=0 next edge, no delivery; assert reset_n=0 mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
